time_entry_loader: RTL and testbench
====================================

Name: time_entry_loader

Overview:
- Writer side of the timer's load interface: collects BCD digits typed on the keypad and assembles a minutes / tens-of-seconds / units-of-seconds value.
- Validates the value, then issues a single-cycle active-low load strobe with parallel data into the stopped timer chain (MOD6 tens counter, MOD10 units and minutes counters).
- Sits between the keypad encoder and the timer datapath.

Parameters:
- DIGIT_W, 4, width of one BCD digit.
- MAX_DIGITS, 3, number of digits captured (min, tens, units).
- TENS_MAX, 5, largest legal tens-of-seconds digit (MOD6 counter range).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- clrn  in  1  synchronous active-low reset.
- key_valid  in  1  high while a key is held; level, may last many cycles.
- key_code  in  4  code of the pressed key; 0-9 are digits, 10-15 are ignored.
- start  in  1  level request to load the entered time into the timer.
- clear  in  1  level request to discard the entry.
- timer_running  in  1  high while the timer counts; a load is illegal then.
- loadn  out  1  active-low load strobe to the timer counters.
- data_min  out  4  minutes digit.
- data_tens  out  4  tens-of-seconds digit.
- data_units  out  4  units-of-seconds digit.
- digit_count  out  2  digits accepted in the current entry, 0..3.
- entry_busy  out  1  high in ENTRY state.
- invalid  out  1  sticky flag: last start rejected because data_tens > TENS_MAX.

Behaviour:
- Reset (clrn=0 at posedge):
  - State returns to IDLE.
  - Outputs: loadn=1, all digits=0, digit_count=0, invalid=0, entry_busy=0.
  - Key and start edge-detect registers are cleared.
  - Reset overrides every other input, including mid-LOAD: loadn is 1 in the cycle after the reset edge.
- Key edge detect:
  - A key is accepted only on a 0->1 transition of registered key_valid; one press yields one digit.
  - Holding the key adds nothing more.
  - The rising edge is detected one cycle after key_valid rises; digits update on the following edge (2-cycle latency).
- Digit accept, only when key_code <= 9 and digit_count < MAX_DIGITS:
  - Shift left: min <= tens, tens <= units, units <= key_code.
  - digit_count increments; invalid clears.
  - Codes 10-15 and a 4th digit are dropped with no state change.
- Start: acts on the rising edge of start only.
- Priority within one cycle: clrn > clear > start edge > key edge. A lower-priority event in the same cycle is lost, not queued.
- States:
  - IDLE: digit_count=0. A digit moves to ENTRY. A start edge is ignored (nothing entered).
  - ENTRY: entry_busy=1. Accepts digits.
    - clear -> IDLE, digits zeroed.
    - start edge with timer_running=1 -> ignored, stay in ENTRY.
    - start edge with data_tens > TENS_MAX -> invalid=1, stay in ENTRY, digits kept.
    - Otherwise -> LOAD.
  - LOAD: loadn=0 for exactly one cycle; data_* stable during it. Always -> DONE.
  - DONE: loadn=1; digits are held on data_* for display.
    - A digit edge starts a new entry: digits zeroed, the new digit loaded as units, digit_count=1, -> ENTRY.
    - clear -> IDLE.
    - A start edge is ignored.
- Arithmetic: none beyond the shift. Digits are never arithmetically modified; a partial entry is right-aligned (e.g. "4" gives 0:04).
- loadn is glitch-free: driven from a register, not decoded combinationally from state.

Decomposition:
- Shared package timer_pkg holds:
  - DIGIT_W, TENS_MAX, MAX_DIGITS constants.
  - State enum entry_state_t {IDLE, ENTRY, LOAD, DONE}.
  - BCD digit typedef shared with the counter blocks.
- One sub-module: edge_rise (2-flop registered rising-edge detector with synchronous active-low clear), instantiated for key_valid and start.

Test Plan:
- Reset then keys 1,3,5 (each held 5 cycles) then start with timer_running=0 -> exactly one loadn=0 cycle with min=1, tens=3, units=5; state DONE; digit_count=3.
- Keys 2,7,0 then start -> no loadn pulse, invalid=1, digits stay 2/7/0; then clear -> all digits 0, state IDLE, invalid=0.
- Key 4 held 20 cycles, then key 11, then start -> single digit only: 0/0/4 loaded; key 11 ignored; one loadn pulse.
- Keys 1,2,3,9 -> 4th digit dropped, data remains 1/2/3.
- Keys 1,0,0 then start with timer_running=1 -> no loadn; after timer_running=0 and a new start edge -> loadn pulse with 1/0/0.
- Keys 5,0 then start held high while clrn=0 on the LOAD cycle -> loadn=1 on the next cycle, all outputs 0; start held after reset produces no pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: digit width, legal ranges, loader state encoding.
package timer_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 3;
  localparam int TENS_MAX   = 5;

  // One BCD digit as carried between the loader and the counter chain.
  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } entry_state_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: two flops, pulse is high for one cycle
// after the input is first seen high. Clear zeroes both flops.
module edge_rise (
  input  logic clock,
  input  logic clrn,
  input  logic i_d,
  output logic o_rise
);

  logic r_q1;
  logic r_q2;

  // Sample the level, then delay it once more to compare against.
  always_ff @(posedge clock) begin
    if (!clrn) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
    end
  end

  assign o_rise = r_q1 & ~r_q2;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-to-timer loader: shifts BCD digits in, validates the tens digit,
// and fires a one-cycle active-low load strobe into the stopped timer.
module time_entry_loader
  import timer_pkg::*;
#(
  parameter int DIGIT_W    = timer_pkg::DIGIT_W,
  parameter int MAX_DIGITS = timer_pkg::MAX_DIGITS,
  parameter int TENS_MAX   = timer_pkg::TENS_MAX
) (
  input  logic               clock,
  input  logic               clrn,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               start,
  input  logic               clear,
  input  logic               timer_running,
  output logic               loadn,
  output logic [DIGIT_W-1:0] data_min,
  output logic [DIGIT_W-1:0] data_tens,
  output logic [DIGIT_W-1:0] data_units,
  output logic [1:0]         digit_count,
  output logic               entry_busy,
  output logic               invalid
);

  localparam logic [1:0]         MAX_CNT  = 2'(MAX_DIGITS);
  localparam logic [DIGIT_W-1:0] TENS_LIM = DIGIT_W'(TENS_MAX);
  localparam logic [DIGIT_W-1:0] DIG_MAX  = DIGIT_W'(9);

  entry_state_t       r_state, w_state_nxt;
  logic               r_loadn, w_loadn_nxt;
  logic [DIGIT_W-1:0] r_min, r_tens, r_units;
  logic [DIGIT_W-1:0] w_min_nxt, w_tens_nxt, w_units_nxt;
  logic [1:0]         r_cnt, w_cnt_nxt;
  logic               r_invalid, w_invalid_nxt;

  logic w_key_rise;
  logic w_start_rise;
  logic w_key_ok;

  edge_rise u_key_edge (
    .clock  (clock),
    .clrn   (clrn),
    .i_d    (key_valid),
    .o_rise (w_key_rise)
  );

  edge_rise u_start_edge (
    .clock  (clock),
    .clrn   (clrn),
    .i_d    (start),
    .o_rise (w_start_rise)
  );

  assign w_key_ok = w_key_rise && (key_code <= DIG_MAX);

  // State and datapath registers; the strobe is registered so it cannot glitch.
  always_ff @(posedge clock) begin
    if (!clrn) begin
      r_state   <= IDLE;
      r_loadn   <= 1'b1;
      r_min     <= '0;
      r_tens    <= '0;
      r_units   <= '0;
      r_cnt     <= '0;
      r_invalid <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_loadn   <= w_loadn_nxt;
      r_min     <= w_min_nxt;
      r_tens    <= w_tens_nxt;
      r_units   <= w_units_nxt;
      r_cnt     <= w_cnt_nxt;
      r_invalid <= w_invalid_nxt;
    end
  end

  // Next state: clear beats a start edge, which beats a key edge; the loser is dropped.
  always_comb begin
    w_state_nxt   = r_state;
    w_loadn_nxt   = 1'b1;
    w_min_nxt     = r_min;
    w_tens_nxt    = r_tens;
    w_units_nxt   = r_units;
    w_cnt_nxt     = r_cnt;
    w_invalid_nxt = r_invalid;

    case (r_state)
      IDLE: begin
        if (clear) begin
          w_min_nxt     = '0;
          w_tens_nxt    = '0;
          w_units_nxt   = '0;
          w_cnt_nxt     = '0;
          w_invalid_nxt = 1'b0;
        end else if (w_start_rise) begin
          // nothing entered yet, so there is nothing to load
        end else if (w_key_ok) begin
          w_units_nxt   = key_code;
          w_cnt_nxt     = 2'd1;
          w_invalid_nxt = 1'b0;
          w_state_nxt   = ENTRY;
        end
      end

      ENTRY: begin
        if (clear) begin
          w_min_nxt     = '0;
          w_tens_nxt    = '0;
          w_units_nxt   = '0;
          w_cnt_nxt     = '0;
          w_invalid_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if (w_start_rise) begin
          if (timer_running) begin
            // loading a running chain would corrupt it; drop the request
          end else if (r_tens > TENS_LIM) begin
            w_invalid_nxt = 1'b1;
          end else begin
            w_invalid_nxt = 1'b0;
            w_loadn_nxt   = 1'b0;
            w_state_nxt   = LOAD;
          end
        end else if (w_key_ok && (r_cnt < MAX_CNT)) begin
          w_min_nxt     = r_tens;
          w_tens_nxt    = r_units;
          w_units_nxt   = key_code;
          w_cnt_nxt     = r_cnt + 2'd1;
          w_invalid_nxt = 1'b0;
        end
      end

      LOAD: begin
        w_state_nxt = DONE;
      end

      DONE: begin
        if (clear) begin
          w_min_nxt     = '0;
          w_tens_nxt    = '0;
          w_units_nxt   = '0;
          w_cnt_nxt     = '0;
          w_invalid_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end else if (w_start_rise) begin
          // already loaded; a repeat start does nothing
        end else if (w_key_ok) begin
          w_min_nxt     = '0;
          w_tens_nxt    = '0;
          w_units_nxt   = key_code;
          w_cnt_nxt     = 2'd1;
          w_invalid_nxt = 1'b0;
          w_state_nxt   = ENTRY;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign loadn       = r_loadn;
  assign data_min    = r_min;
  assign data_tens   = r_tens;
  assign data_units  = r_units;
  assign digit_count = r_cnt;
  assign entry_busy  = (r_state == ENTRY);
  assign invalid     = r_invalid;

endmodule

// File: tb/tb_time_entry_loader.sv
// Bench for time_entry_loader: directed keypad/start sequences, expected load
// values queued at issue time and popped by a monitor on each loadn pulse.
module tb_time_entry_loader;

  logic       clock = 1'b0;
  logic       clrn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       timer_running = 1'b0;
  logic       loadn;
  logic [3:0] data_min, data_tens, data_units;
  logic [1:0] digit_count;
  logic       entry_busy;
  logic       invalid;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] u;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_loads = 0;

  time_entry_loader dut (
    .clock         (clock),
    .clrn          (clrn),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .start         (start),
    .clear         (clear),
    .timer_running (timer_running),
    .loadn         (loadn),
    .data_min      (data_min),
    .data_tens     (data_tens),
    .data_units    (data_units),
    .digit_count   (digit_count),
    .entry_busy    (entry_busy),
    .invalid       (invalid)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every cycle with loadn low must match the oldest queued load.
  always @(negedge clock) begin
    if (loadn === 1'b0) begin
      exp_t got;
      got = '{m: data_min, t: data_tens, u: data_units};
      n_loads++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: got %0d/%0d/%0d, required no load pulse",
                 got.m, got.t, got.u);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL load_data: got %0d/%0d/%0d, required %0d/%0d/%0d",
                   got.m, got.t, got.u, e.m, e.t, e.u);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_data(input string name, input int m, input int t, input int u);
    chk({name, "_min"},   32'(data_min),   32'(m));
    chk({name, "_tens"},  32'(data_tens),  32'(t));
    chk({name, "_units"}, 32'(data_units), 32'(u));
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    @(negedge clock);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) @(negedge clock);
    key_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_loadn", 32'(loadn), 1);
    chk_data("rst", 0, 0, 0);
    chk("rst_count", 32'(digit_count), 0);
    chk("rst_busy", 32'(entry_busy), 0);
    chk("rst_invalid", 32'(invalid), 0);
    clrn = 1'b1;
    repeat (2) @(negedge clock);

    // 1,3,5 then start -> one load of 1:35
    press(4'd1, 5); press(4'd3, 5); press(4'd5, 5);
    chk("t1_count", 32'(digit_count), 3);
    chk("t1_busy", 32'(entry_busy), 1);
    chk_data("t1_entry", 1, 3, 5);
    base = n_loads;
    exp_q.push_back('{m: 4'd1, t: 4'd3, u: 4'd5});
    pulse_start();
    chk("t1_pulses", 32'(n_loads - base), 1);
    chk("t1_done_busy", 32'(entry_busy), 0);
    chk("t1_done_count", 32'(digit_count), 3);
    chk("t1_done_loadn", 32'(loadn), 1);
    chk_data("t1_done", 1, 3, 5);

    // 2,7,0 then start -> rejected (tens 7), then clear
    press(4'd2, 5); press(4'd7, 5); press(4'd0, 5);
    base = n_loads;
    pulse_start();
    chk("t2_pulses", 32'(n_loads - base), 0);
    chk("t2_invalid", 32'(invalid), 1);
    chk("t2_busy", 32'(entry_busy), 1);
    chk_data("t2_kept", 2, 7, 0);
    pulse_clear();
    chk_data("t2_clr", 0, 0, 0);
    chk("t2_clr_busy", 32'(entry_busy), 0);
    chk("t2_clr_count", 32'(digit_count), 0);
    chk("t2_clr_invalid", 32'(invalid), 0);

    // 4 held long, then non-digit 11, then start -> 0:04
    press(4'd4, 20);
    chk("t3_hold_count", 32'(digit_count), 1);
    press(4'd11, 5);
    chk("t3_code11_count", 32'(digit_count), 1);
    chk_data("t3_entry", 0, 0, 4);
    base = n_loads;
    exp_q.push_back('{m: 4'd0, t: 4'd0, u: 4'd4});
    pulse_start();
    chk("t3_pulses", 32'(n_loads - base), 1);

    // 1,2,3,9 -> fourth digit dropped
    press(4'd1, 5); press(4'd2, 5); press(4'd3, 5); press(4'd9, 5);
    chk("t4_count", 32'(digit_count), 3);
    chk_data("t4_entry", 1, 2, 3);
    pulse_clear();

    // 1,0,0 with timer running -> blocked; stopped -> loads 1:00
    press(4'd1, 5); press(4'd0, 5); press(4'd0, 5);
    timer_running = 1'b1;
    base = n_loads;
    pulse_start();
    chk("t5_run_pulses", 32'(n_loads - base), 0);
    chk("t5_run_busy", 32'(entry_busy), 1);
    chk("t5_run_invalid", 32'(invalid), 0);
    timer_running = 1'b0;
    exp_q.push_back('{m: 4'd1, t: 4'd0, u: 4'd0});
    pulse_start();
    chk("t5_pulses", 32'(n_loads - base), 1);

    // 5,0 then start held; reset lands on the LOAD cycle
    press(4'd5, 5); press(4'd0, 5);
    chk_data("t6_entry", 0, 5, 0);
    exp_q.push_back('{m: 4'd0, t: 4'd5, u: 4'd0});
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("t6_load_cycle", 32'(loadn), 0);
    clrn = 1'b0;
    @(negedge clock);
    chk("t6_rst_loadn", 32'(loadn), 1);
    chk_data("t6_rst", 0, 0, 0);
    chk("t6_rst_count", 32'(digit_count), 0);
    chk("t6_rst_busy", 32'(entry_busy), 0);
    clrn = 1'b1;
    base = n_loads;
    repeat (10) @(negedge clock);
    chk("t6_held_pulses", 32'(n_loads - base), 0);
    chk("t6_held_loadn", 32'(loadn), 1);
    start = 1'b0;
    repeat (3) @(negedge clock);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
